// File: rtl/uart_frame_pkg.sv
// Line constants, FSM state types and a counter-sizing helper shared by the
// UART image initiator and its word deserializer.
package uart_frame_pkg;

    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;
    localparam logic UART_IDLE  = 1'b1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Never returns less than 1, so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_word_deserializer.sv
// Receives one 8N1 word from an asynchronous rx line: synchroniser, mid-bit
// sampling FSM, and a one-cycle strobe carrying the word and its stop-bit status.
module uart_word_deserializer
    import uart_frame_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic                     word_valid,
    output logic [BITS_PER_WORD-1:0] word_data,
    output logic                     word_err
);

    localparam int CNT_W = clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W = clog2(BITS_PER_WORD);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_WORD - 1);

    logic                     meta_q, meta_d;
    logic                     sync_q, sync_d;
    logic                     prev_q, prev_d;
    rx_state_t                state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BIT_W-1:0]         bit_q, bit_d;
    logic [BITS_PER_WORD-1:0] shift_q, shift_d;
    logic                     word_valid_q, word_valid_d;
    logic [BITS_PER_WORD-1:0] word_data_q, word_data_d;
    logic                     word_err_q, word_err_d;

    always_comb begin
        meta_d       = rx;
        sync_d       = meta_q;
        prev_d       = sync_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        word_valid_d = 1'b0;
        word_data_d  = word_data_q;
        word_err_d   = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (prev_q == UART_IDLE && sync_q == UART_START) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid-start was only a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = (sync_q == UART_START) ? RX_DATA : RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = BITS_PER_WORD'({sync_q, shift_q} >> 1);
                    if (bit_q == LAST_BIT) state_d = RX_STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d        = '0;
                    state_d      = RX_IDLE;
                    word_valid_d = 1'b1;
                    word_data_d  = shift_q;
                    word_err_d   = (sync_q != UART_STOP);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q       <= UART_IDLE;
            sync_q       <= UART_IDLE;
            prev_q       <= UART_IDLE;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            word_err_q   <= 1'b0;
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            word_err_q   <= word_err_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign word_err   = word_err_q;

endmodule

// File: rtl/uart_image_initiator.sv
// Far-end partner of the UART image filter: serialises one parallel frame onto tx
// and reassembles the filtered frame returned on rx into a held parallel frame.
module uart_image_initiator
    import uart_frame_pkg::*;
#(
    parameter int R_I              = 7,
    parameter int C_I              = 7,
    parameter int W_I              = 8,
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    localparam int W_OUT           = R_I * C_I * W_I,
    localparam int NUM_WORDS       = W_OUT / BITS_PER_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_OUT-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             tx,
    input  logic             rx,
    output logic [W_OUT-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W  = clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W  = clog2(BITS_PER_WORD);
    localparam int WORD_W = clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_WORDS - 1);

    // Both ports transfer on a cycle where valid and ready are high together;
    // valid never waits on ready, and m_valid/m_data hold until that cycle.

    tx_state_t         tx_state_q, tx_state_d;
    logic [W_OUT-1:0]  tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
    logic [WORD_W-1:0] tx_word_q, tx_word_d;
    logic              tx_q, tx_d;
    logic              s_ready_q, s_ready_d;

    // The whole frame shifts right one bit per data bit, which yields word 0
    // first and LSB first without any word indexing.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_word_d  = tx_word_q;
        tx_d       = tx_q;
        s_ready_d  = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                tx_d      = UART_IDLE;
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    tx_state_d = TX_START;
                    tx_shift_d = s_data;
                    tx_word_d  = '0;
                    tx_cnt_d   = '0;
                    tx_d       = UART_START;
                    s_ready_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == FULL_M1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == FULL_M1) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                        tx_d       = UART_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == FULL_M1) begin
                    tx_cnt_d = '0;
                    if (tx_word_q == LAST_WORD) begin
                        tx_state_d = TX_IDLE;
                        tx_d       = UART_IDLE;
                        s_ready_d  = 1'b1;
                    end else begin
                        tx_word_d  = tx_word_q + 1'b1;
                        tx_state_d = TX_START;
                        tx_d       = UART_START;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    logic                     word_valid;
    logic [BITS_PER_WORD-1:0] word_data;
    logic                     word_err;

    uart_word_deserializer #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .word_valid(word_valid),
        .word_data (word_data),
        .word_err  (word_err)
    );

    logic [W_OUT-1:0]  asm_q, asm_d;
    logic [WORD_W-1:0] rx_word_q, rx_word_d;
    logic [W_OUT-1:0]  m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic [W_OUT-1:0]  full_frame;
    logic              consume;
    logic              complete;

    // Clearing on consume comes first so that flags raised by the word arriving
    // in the same cycle belong to the next frame.
    always_comb begin
        asm_d       = asm_q;
        rx_word_d   = rx_word_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        full_frame  = asm_q;
        complete    = 1'b0;
        consume     = m_valid_q && m_ready;

        if (consume) begin
            m_valid_d   = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        if (word_valid) begin
            full_frame[int'(rx_word_q) * BITS_PER_WORD +: BITS_PER_WORD] = word_data;
            asm_d = full_frame;
            if (word_err) frame_err_d = 1'b1;
            if (rx_word_q == LAST_WORD) begin
                rx_word_d = '0;
                complete  = 1'b1;
            end else begin
                rx_word_d = rx_word_q + 1'b1;
            end
        end

        if (complete) begin
            if (!m_valid_q || consume) begin
                m_data_d  = full_frame;
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_shift_q  <= '0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_word_q   <= '0;
            tx_q        <= UART_IDLE;
            s_ready_q   <= 1'b0;
            asm_q       <= '0;
            rx_word_q   <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_shift_q  <= tx_shift_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_word_q   <= tx_word_d;
            tx_q        <= tx_d;
            s_ready_q   <= s_ready_d;
            asm_q       <= asm_d;
            rx_word_q   <= rx_word_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign tx        = tx_q;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
